ahsqr_square_residual: RTL

//   Inverse-direction companion to the approximate square-root unit: takes a radicand R and the

---
 rtl/ahsqr_pkg.sv | 12 +
 rtl/ahsqr_shift_add_mul.sv | 60 ++++++
 rtl/ahsqr_square_residual.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ahsqr_pkg.sv
// Shared constants for the square/residual accuracy monitor: default root width
// and FSM state encodings.
package ahsqr_pkg;

    localparam int DEF_W_ROOT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/ahsqr_shift_add_mul.sv
// Iterative LSB-first shift-add squarer: one multiplier bit per cycle, fixed
// W_ROOT-cycle latency regardless of operand value.
module ahsqr_shift_add_mul
    import ahsqr_pkg::*;
#(
    parameter int W_ROOT = DEF_W_ROOT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_ROOT-1:0]     operand,
    output logic                  busy,
    output logic                  done,
    output logic [2*W_ROOT-1:0]   product
);

    localparam int W_RAD = 2 * W_ROOT;
    localparam int CNT_W = $clog2(W_ROOT + 1);

    logic [W_RAD-1:0]  mcand_r;
    logic [W_ROOT-1:0] mplr_r;
    logic [W_RAD-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;

    // done flags the cycle whose closing edge performs the final iteration
    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == CNT_W'(W_ROOT - 1));
    assign product = acc_r;

    // Operand load on start, then one shift-add step per cycle while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= {W_RAD{1'b0}};
            mplr_r  <= {W_ROOT{1'b0}};
            acc_r   <= {W_RAD{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else if (start) begin
            mcand_r <= {{W_ROOT{1'b0}}, operand};
            mplr_r  <= operand;
            acc_r   <= {W_RAD{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
        end else if (busy_r) begin
            if (mplr_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r <= {mcand_r[W_RAD-2:0], 1'b0};
            mplr_r  <= {1'b0, mplr_r[W_ROOT-1:1]};
            cnt_r   <= cnt_r + CNT_W'(1);
            busy_r  <= !done;
        end else begin
            busy_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/ahsqr_square_residual.sv
// Accuracy monitor for the square-root stage: squares the delivered root and
// reports q*q, the signed residual R - q*q, its magnitude and direction.
module ahsqr_square_residual
    import ahsqr_pkg::*;
#(
    parameter int W_ROOT = DEF_W_ROOT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*W_ROOT-1:0]   R,
    input  logic [W_ROOT-1:0]     root,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*W_ROOT-1:0]   square,
    output logic [2*W_ROOT:0]     residual,
    output logic [2*W_ROOT-1:0]   abs_err,
    output logic                  exact,
    output logic                  over
);

    localparam int W_RAD = 2 * W_ROOT;

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [W_RAD-1:0] r_r;
    logic [W_RAD-1:0] square_r;
    logic [W_RAD:0]   residual_r;
    logic [W_RAD-1:0] abs_err_r;
    logic             exact_r;
    logic             over_r;

    logic             accept_s;
    logic             out_fire_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic [W_RAD-1:0] product_s;
    logic [W_RAD:0]   residual_s;
    logic [W_RAD-1:0] abs_err_s;
    logic             over_s;
    logic             exact_s;

    assign accept_s   = in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign square    = square_r;
    assign residual  = residual_r;
    assign abs_err   = abs_err_r;
    assign exact     = exact_r;
    assign over      = over_r;

    ahsqr_shift_add_mul #(
        .W_ROOT (W_ROOT)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s),
        .operand (root),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Next-state decode; a MUL state with an idle multiplier falls back to IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_MUL;
                else          next_state_s = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_done_s)       next_state_s = ST_CALC;
                else if (!mul_busy_s) next_state_s = ST_IDLE;
                else                  next_state_s = ST_MUL;
            end
            ST_CALC: next_state_s = ST_DONE;
            ST_DONE: begin
                if (out_fire_s) next_state_s = ST_IDLE;
                else            next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Residual and flags from the finished product; magnitude via an unsigned
    // subtraction in the safe direction so no sign bit needs discarding
    always_comb begin
        residual_s = {1'b0, r_r} - {1'b0, product_s};
        over_s     = (product_s > r_r);
        exact_s    = (product_s == r_r);
        if (over_s) begin
            abs_err_s = product_s - r_r;
        end else begin
            abs_err_s = r_r - product_s;
        end
    end

    // FSM, handshake flags and radicand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            r_r         <= {W_RAD{1'b0}};
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (next_state_s == ST_DONE);
            if (accept_s) begin
                r_r <= R;
            end else begin
                r_r <= r_r;
            end
        end
    end

    // Result registers load once in CALC and otherwise keep their last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            square_r   <= {W_RAD{1'b0}};
            residual_r <= {(W_RAD+1){1'b0}};
            abs_err_r  <= {W_RAD{1'b0}};
            exact_r    <= 1'b0;
            over_r     <= 1'b0;
        end else if (state_r == ST_CALC) begin
            square_r   <= product_s;
            residual_r <= residual_s;
            abs_err_r  <= abs_err_s;
            exact_r    <= exact_s;
            over_r     <= over_s;
        end else begin
            square_r   <= square_r;
            residual_r <= residual_r;
            abs_err_r  <= abs_err_r;
            exact_r    <= exact_r;
            over_r     <= over_r;
        end
    end

endmodule
